// File: rtl/systolic_drain_if.sv
// Purpose: bundles the accumulator-side and result-side signals of the systolic drain stage.
// Latency: none (wires only).
// Backpressure: z_yumi_o pops array slots; ready_i stalls the result stream.
interface systolic_drain_if #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
);
    localparam int n_slots_lp = array_width_p * array_height_p;
    localparam int row_w_lp   = (array_height_p > 1) ? $clog2(array_height_p) : 1;
    localparam int col_w_lp   = (array_width_p  > 1) ? $clog2(array_width_p)  : 1;

    logic [width_p*n_slots_lp-1:0] z_i;
    logic [n_slots_lp-1:0]         z_valid_i;
    logic [n_slots_lp-1:0]         z_yumi_o;
    logic [width_p-1:0]            data_o;
    logic [row_w_lp-1:0]           row_o;
    logic [col_w_lp-1:0]           col_o;
    logic                          last_o;
    logic                          valid_o;
    logic                          ready_i;

    // Drain block view: consumes accumulators, produces the result stream.
    modport slave (
        input  z_i, z_valid_i, ready_i,
        output z_yumi_o, data_o, row_o, col_o, last_o, valid_o
    );

    // Environment view: the array plus the downstream result FIFO.
    modport master (
        output z_i, z_valid_i, ready_i,
        input  z_yumi_o, data_o, row_o, col_o, last_o, valid_o
    );
endinterface

// File: rtl/systolic_drain.sv
// Purpose: serialises systolic PE accumulators in row-major order into one tagged stream (optional ReLU via SYSTOLIC_DRAIN_RELU_EN).
// Latency: 1 cycle from slot capture to valid_o; one word per cycle sustained.
// Backpressure: output register holds while valid_o && !ready_i; no slot is yumi'd during the hold.
module systolic_drain #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    systolic_drain_if.slave bus
);
    localparam int n_slots_lp = array_width_p * array_height_p;
    localparam int slot_w_lp  = (n_slots_lp > 1)     ? $clog2(n_slots_lp)     : 1;
    localparam int row_w_lp   = (array_height_p > 1) ? $clog2(array_height_p) : 1;
    localparam int col_w_lp   = (array_width_p  > 1) ? $clog2(array_width_p)  : 1;

    // The slot mapping k = r + c*W only tiles the bus cleanly for a square array.
    if (array_width_p != array_height_p) begin : g_non_square
        $fatal(1, "systolic_drain: array_width_p must equal array_height_p");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    logic [row_w_lp-1:0]   r_ptr;
    logic [col_w_lp-1:0]   c_ptr;
    logic [width_p-1:0]    data_q;
    logic [row_w_lp-1:0]   row_q;
    logic [col_w_lp-1:0]   col_q;
    logic                  last_q;

    logic [slot_w_lp-1:0]  slot_k;
    logic [width_p-1:0]    sel_word;
    logic                  sel_vld;
    logic [width_p-1:0]    load_word;
    logic                  at_last;
    logic                  cap;

    // Map the raster pointer onto the column-major slot index of the flattened bus.
    always_comb begin
        slot_k = slot_w_lp'(r_ptr) + slot_w_lp'(slot_w_lp'(c_ptr) * slot_w_lp'(array_width_p));
    end

    // Select the current slot's word and valid.
    always_comb begin
        sel_word = '0;
        sel_vld  = 1'b0;
        for (int i = 0; i < n_slots_lp; i++) begin
            if (slot_w_lp'(i) == slot_k) begin
                sel_word = bus.z_i[i*width_p +: width_p];
                sel_vld  = bus.z_valid_i[i];
            end
        end
    end

    // Optional rectification of negative accumulators before they enter the output register.
    always_comb begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
        load_word = sel_word[width_p-1] ? '0 : sel_word;
`else
        load_word = sel_word;
`endif
    end

    // Capture when the current slot is valid and the output register is free or draining this cycle.
    always_comb begin
        at_last = (r_ptr == row_w_lp'(array_height_p - 1)) &&
                  (c_ptr == col_w_lp'(array_width_p - 1));
        cap     = reset_i && sel_vld && ((state == EMPTY) || bus.ready_i);
    end

    // One-hot yumi on the slot being captured.
    always_comb begin
        bus.z_yumi_o = '0;
        for (int i = 0; i < n_slots_lp; i++) begin
            if (slot_w_lp'(i) == slot_k) begin
                bus.z_yumi_o[i] = cap;
            end
        end
    end

    // Output register, raster pointer and EMPTY/FULL state.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state  <= EMPTY;
            r_ptr  <= '0;
            c_ptr  <= '0;
            data_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            last_q <= 1'b0;
        end else if (cap) begin
            state  <= FULL;
            data_q <= load_word;
            row_q  <= r_ptr;
            col_q  <= c_ptr;
            last_q <= at_last;
            if (c_ptr == col_w_lp'(array_width_p - 1)) begin
                c_ptr <= '0;
                r_ptr <= (r_ptr == row_w_lp'(array_height_p - 1)) ? '0 : r_ptr + row_w_lp'(1);
            end else begin
                c_ptr <= c_ptr + col_w_lp'(1);
            end
        end else if ((state == FULL) && bus.ready_i) begin
            state <= EMPTY;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.row_o   = row_q;
    assign bus.col_o   = col_q;
    assign bus.last_o  = last_q;
    assign bus.valid_o = (state == FULL);
endmodule

// File: tb/tb_systolic_drain.sv
// Purpose: directed self-checking bench for the 2x2 systolic drain stage.
// Latency: expects captured words on the edge after yumi.
// Backpressure: exercises ready_i stalls, in-order waits and reset mid-drain.
module tb_systolic_drain;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // Yumi mask for each raster step: slot k = r + c*2.
    localparam logic [3:0] YM [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    localparam logic       ER [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic       EC [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    systolic_drain_if #(.width_p(32), .array_width_p(2), .array_height_p(2)) bus ();

    systolic_drain #(.width_p(32), .array_width_p(2), .array_height_p(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_slot(input int r, input int c, input logic [31:0] v, input logic vld);
        int k;
        k = r + c * 2;
        bus.z_i[k*32 +: 32] = v;
        bus.z_valid_i[k]    = vld;
    endtask

    task automatic set_all(input logic [31:0] base, input logic vld);
        for (int i = 0; i < 4; i++) set_slot(int'(ER[i]), int'(EC[i]), base + 32'(i), vld);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input int i, input logic last);
        chk({tag, "_data"}, 64'(bus.data_o), 64'(d));
        chk({tag, "_row"},  64'(bus.row_o), 64'(ER[i]));
        chk({tag, "_col"},  64'(bus.col_o), 64'(EC[i]));
        chk({tag, "_last"}, 64'(bus.last_o), 64'(last));
        chk({tag, "_vld"},  64'(bus.valid_o), 64'd1);
    endtask

    initial begin
        bus.z_i       = '0;
        bus.z_valid_i = '0;
        bus.ready_i   = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_vld",  64'(bus.valid_o), 64'd0);
        chk("rst_data", 64'(bus.data_o), 64'd0);
        chk("rst_row",  64'(bus.row_o), 64'd0);
        chk("rst_col",  64'(bus.col_o), 64'd0);
        chk("rst_last", 64'(bus.last_o), 64'd0);
        chk("rst_yumi", 64'(bus.z_yumi_o), 64'd0);
        reset_i = 1'b1;

        // Raster order, ready held high
        set_all(32'd1, 1'b1);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ras_yumi", 64'(bus.z_yumi_o), 64'(YM[i]));
            tick();
            chk_out("ras", 32'd1 + 32'(i), i, i == 3);
        end
        bus.z_valid_i = '0;
        #1 chk("ras_idle_yumi", 64'(bus.z_yumi_o), 64'd0);
        tick();
        chk("ras_empty", 64'(bus.valid_o), 64'd0);

        // Backpressure after the first capture
        set_all(32'd1, 1'b1);
        bus.ready_i = 1'b0;
        #1 chk("bp_yumi0", 64'(bus.z_yumi_o), 64'(YM[0]));
        tick();
        chk_out("bp_first", 32'd1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_hold_yumi", 64'(bus.z_yumi_o), 64'd0);
            tick();
            chk_out("bp_hold", 32'd1, 0, 1'b0);
        end
        bus.ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1 chk("bp_yumi", 64'(bus.z_yumi_o), 64'(YM[i]));
            tick();
            chk_out("bp_rel", 32'd1 + 32'(i), i, i == 3);
        end
        bus.z_valid_i = '0;
        tick();
        chk("bp_empty", 64'(bus.valid_o), 64'd0);

        // In-order wait: (0,1) valid alone must not be taken
        set_slot(0, 1, 32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 chk("wait_yumi", 64'(bus.z_yumi_o), 64'd0);
            tick();
            chk("wait_vld", 64'(bus.valid_o), 64'd0);
        end
        set_slot(0, 0, 32'd5, 1'b1);
        #1 chk("wait_yumi0", 64'(bus.z_yumi_o), 64'(YM[0]));
        tick();
        chk_out("wait_w0", 32'd5, 0, 1'b0);
        tick();
        chk_out("wait_w1", 32'd7, 1, 1'b0);
        bus.z_valid_i = '0;
        set_slot(1, 0, 32'd8, 1'b1);
        set_slot(1, 1, 32'd9, 1'b1);
        tick();
        chk_out("wait_w2", 32'd8, 2, 1'b0);
        tick();
        chk_out("wait_w3", 32'd9, 3, 1'b1);
        bus.z_valid_i = '0;
        tick();
        chk("wait_empty", 64'(bus.valid_o), 64'd0);

        // Back-to-back matrices, no idle cycle between them
        set_all(32'd11, 1'b1);
        for (int i = 0; i < 8; i++) begin
            #1 chk("b2b_yumi", 64'(bus.z_yumi_o), 64'(YM[i % 4]));
            tick();
            chk_out("b2b", ((i < 4) ? 32'd11 : 32'd21) + 32'(i % 4), i % 4, (i % 4) == 3);
            if (i == 3) set_all(32'd21, 1'b1);
        end
        bus.z_valid_i = '0;
        tick();
        chk("b2b_empty", 64'(bus.valid_o), 64'd0);

        // Reset mid-drain with a held word
        set_all(32'd1, 1'b1);
        tick();
        tick();
        chk_out("mid_w1", 32'd2, 1, 1'b0);
        bus.ready_i = 1'b0;
        reset_i     = 1'b0;
        #1 chk("mid_rst_yumi", 64'(bus.z_yumi_o), 64'd0);
        tick();
        chk("mid_rst_vld",  64'(bus.valid_o), 64'd0);
        chk("mid_rst_data", 64'(bus.data_o), 64'd0);
        chk("mid_rst_row",  64'(bus.row_o), 64'd0);
        chk("mid_rst_col",  64'(bus.col_o), 64'd0);
        reset_i     = 1'b1;
        bus.ready_i = 1'b1;
        #1 chk("mid_rel_yumi", 64'(bus.z_yumi_o), 64'(YM[0]));
        tick();
        chk_out("mid_rel_w0", 32'd1, 0, 1'b0);

        // Negative accumulator handling, starting from a fresh pointer
        bus.z_valid_i = '0;
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        set_slot(0, 0, 32'hFFFF_FFF6, 1'b1);
        set_slot(0, 1, 32'h0000_000A, 1'b1);
        tick();
`ifdef SYSTOLIC_DRAIN_RELU_EN
        chk_out("neg_w0", 32'd0, 0, 1'b0);
`else
        chk_out("neg_w0", 32'hFFFF_FFF6, 0, 1'b0);
`endif
        bus.z_valid_i = '0;
        set_slot(0, 1, 32'h0000_000A, 1'b1);
        tick();
        chk_out("neg_w1", 32'd10, 1, 1'b0);
        bus.z_valid_i = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream stage of the systolic MAC array.
- Consumes the array's flattened per-PE accumulator bus and its valid/yumi handshakes.
- Serialises the results in fixed raster order (row-major: row 0 col 0, row 0 col 1, …) into one width_p stream, tagging each word with its row/col index and an end-of-matrix marker.
- Feeds the writeback/result FIFO.

Parameters:
- width_p, 32: accumulator/result word width in bits.
- array_width_p, 2: PE columns. Must equal array_height_p; a non-square configuration is a fatal elaboration error.
- array_height_p, 2: PE rows.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset.
- z_i  in  width_p*array_width_p*array_height_p  flattened accumulators. PE (r,c) occupies slot k = r + c*array_width_p, bits [width_p*(k+1)-1 : width_p*k].
- z_valid_i  in  array_width_p*array_height_p  per-slot valid, indexed by k.
- z_yumi_o  out  array_width_p*array_height_p  per-slot yumi, indexed by k.
- data_o  out  width_p  result word.
- row_o  out  max(1,$clog2(array_height_p))  PE row of data_o.
- col_o  out  max(1,$clog2(array_width_p))  PE column of data_o.
- last_o  out  1  high with the final word (r=H-1, c=W-1) of a matrix.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream ready.

Behaviour:
- Reset (reset_i==0 at a clock edge):
  - valid_o=0, data_o=0, row_o=0, col_o=0, last_o=0, z_yumi_o=0.
  - Pointer (r_ptr, c_ptr) = (0,0); FSM = EMPTY.
  - Reset mid-transfer discards the held word and restarts at (0,0). Slots already yumi'd are lost.
- Pointer:
  - Selects the current slot k = r_ptr + c_ptr*array_width_p.
  - c_ptr increments on each capture. When it wraps at W-1 it goes to 0 and r_ptr increments. r_ptr wraps at H-1 to 0.
- Strict order:
  - No slot is skipped. The block waits indefinitely on the current slot even if other slots are valid.
- Capture condition: cap = z_valid_i[k] && (FSM==EMPTY || ready_i).
- z_yumi_o:
  - Combinational one-hot: bit k = cap, all other bits 0.
  - Never asserted unless z_valid_i[k] is high in the same cycle.
- On cap, registered:
  - data_o = z_i slot k; row_o = r_ptr; col_o = c_ptr.
  - last_o = (r_ptr==H-1 && c_ptr==W-1); valid_o = 1; pointer advances.
- FSM (two states):
  - EMPTY→FULL on cap.
  - FULL→EMPTY when ready_i && !cap.
  - FULL→FULL when ready_i && cap (back-to-back, 1 word/cycle), or when !ready_i (hold).
- Output stability:
  - While valid_o && !ready_i, data_o/row_o/col_o/last_o are stable and z_yumi_o=0.
- Latency: 1 cycle from the cap edge to valid_o.
- Throughput: one word per cycle with ready_i held high and slots valid.
- Full drain of an H×W matrix takes exactly H*W captures. The next matrix starts at (0,0) with no idle cycle required.
- Valid hold-off: a slot whose valid drops before capture is simply not taken; the block keeps waiting on it.
- Simultaneous: ready_i and a new capture in the same cycle replace the output register; no bubble, no duplication.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_RELU_EN.
- Defined: captured words are treated as signed two's complement; if the MSB is 1, data_o is loaded with 0 instead. Index, last_o and handshakes are unchanged.
- Undefined: data_o is the raw accumulator value.

Test Plan:
- Raster order: 2×2, slots (0,0)=1, (0,1)=2, (1,0)=3, (1,1)=4 all valid, ready_i=1.
  - Expect data_o 1,2,3,4 on consecutive cycles with (row,col) (0,0),(0,1),(1,0),(1,1).
  - last_o only on 4; each z_yumi_o bit pulses exactly once.
- Backpressure: same data with ready_i=0 for 3 cycles after the first capture.
  - data_o=1 held stable, z_yumi_o=0 throughout.
  - On ready_i=1, 2 follows the next cycle; no loss or duplication.
- In-order wait: only slot (0,1)=7 valid for 5 cycles → no output and no yumi. Then assert (0,0)=5 → outputs 5 then 7.
- Back-to-back matrices: two consecutive 2×2 drains with ready_i=1 → 8 words, last_o on word 4 and word 8, indices restart at (0,0).
- Reset mid-drain: reset_i=0 after word 2 with valid_o=1 and ready_i=0 → next cycle valid_o=0, z_yumi_o=0. After release, the pointer is at (0,0).
- RELU (macro defined): slot (0,0)=32'hFFFF_FFF6 (-10) → data_o=0; slot (0,1)=32'h0000_000A → data_o=10.
